// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, sync windows and pixel pipeline types
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
    localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // One pixel's worth of pin state, carried through the delay pipeline together
    typedef struct packed {
        rgb_t rgb;
        logic hs;
        logic vs;
        logic active;
    } pix_t;

    // Half-open window test [lo, hi) on a 10-bit scan counter
    function automatic logic in_window(input logic [9:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_pixel_delay.sv
// vga_pixel_delay: tick-enabled DEPTH-stage shift register with an async reset value
module vga_pixel_delay #(
    parameter int             W       = 3,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            // First stage samples the raw pixel state on each tick
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n)
                    stage[i] <= RST_VAL;
                else if (en)
                    stage[i] <= d;
        end else begin : g_rest
            // Later stages shift the previous stage along on each tick
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n)
                    stage[i] <= RST_VAL;
                else if (en)
                    stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: VGA scan counters, coordinate issue and pin-aligned colour/sync output
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  xPixel,
    output logic [8:0]  yPixel,
    input  logic [7:0]  VGAr_in,
    input  logic [7:0]  VGAg_in,
    input  logic [7:0]  VGAb_in,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam pix_t          PIX_IDLE = '{rgb: '0, hs: 1'b1, vs: 1'b1, active: 1'b0};

    logic [DW-1:0] div;
    logic [9:0]    hcount;
    logic [9:0]    vcount;
    logic          pix_tick;
    logic          h_wrap;
    logic          v_wrap;
    logic          frame_wrap;
    logic          active;
    rgb_t          rgb_in;
    pix_t          pix_raw;
    pix_t          pix_out;

    assign pix_tick   = div == DIV_LAST;
    assign h_wrap     = hcount == H_LAST;
    assign v_wrap     = vcount == V_LAST;
    assign frame_wrap = pix_tick && h_wrap && v_wrap;
    assign active     = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));

    // System-clock divider producing one pixel tick every CLK_DIV clocks
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            div <= '0;
        else
            div <= pix_tick ? '0 : div + 1'b1;

    // Horizontal and vertical scan counters, both advancing on pixel ticks
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_tick) begin
            hcount <= h_wrap ? '0 : hcount + 10'd1;
            if (h_wrap)
                vcount <= v_wrap ? '0 : vcount + 10'd1;
        end

    // Frame housekeeping: pulse and count on every return to (0,0)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= frame_wrap;
            frame_count <= frame_count + 16'(frame_wrap);
        end

    // Raw pin state for the current coordinate; the controller's colour is gated
    // at entry so blanked pixels travel down the pipe as black
    always_comb begin
        rgb_in         = '{r: VGAr_in, g: VGAg_in, b: VGAb_in};
        pix_raw.rgb    = active ? rgb_in : '0;
        pix_raw.hs     = !in_window(hcount, HS_START, HS_END);
        pix_raw.vs     = !in_window(vcount, VS_START, VS_END);
        pix_raw.active = active;
    end

    vga_pixel_delay #(
        .W       ($bits(pix_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (PIX_IDLE)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_tick),
        .d     (pix_raw),
        .q     (pix_out)
    );

    assign xPixel      = active ? hcount : '0;
    assign yPixel      = active ? vcount[8:0] : '0;
    assign VGA_R       = pix_out.rgb.r;
    assign VGA_G       = pix_out.rgb.g;
    assign VGA_B       = pix_out.rgb.b;
    assign VGA_HS      = pix_out.hs;
    assign VGA_VS      = pix_out.vs;
    assign VGA_BLANK_N = pix_out.active;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = div >= DIV_HALF;

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: randomized self-checking bench against an arithmetic scan model
module tb_vga_scan_timing;

    localparam int CD = 4;
    localparam int HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int PD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  x_pixel;
    logic [8:0]  y_pixel;
    logic [7:0]  r_in, g_in, b_in;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, blank_n, sync_n, vga_clk, frame_start;
    logic [15:0] frame_count;
    logic [7:0]  kr, kg, kb;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int pulses = 0;
    int last_pulse = -1;
    bit in_reset = 1'b1;

    always #5 clk = ~clk;

    // Stand-in drawing controller: colour is a keyed function of the coordinate
    always_comb begin
        r_in = x_pixel[7:0] ^ kr;
        g_in = y_pixel[7:0] ^ kg;
        b_in = 8'(x_pixel + {1'b0, y_pixel}) ^ kb;
    end

    vga_scan_timing #(
        .CLK_DIV (CD), .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB), .PIPE_DLY (PD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .xPixel      (x_pixel),
        .yPixel      (y_pixel),
        .VGAr_in     (r_in),
        .VGAg_in     (g_in),
        .VGAb_in     (b_in),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .VGA_BLANK_N (blank_n),
        .VGA_SYNC_N  (sync_n),
        .VGA_CLK     (vga_clk),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pins follow from the tick count alone: ticks since release = n / CD
    task automatic check_all();
        int k, h, v, j, hj, vj;
        logic a, aj, ehs, evs;
        logic [7:0] er, eg, eb;
        if (in_reset) begin
            chk("rst_x", x_pixel, 0);
            chk("rst_y", y_pixel, 0);
            chk("rst_r", vga_r, 0);
            chk("rst_g", vga_g, 0);
            chk("rst_b", vga_b, 0);
            chk("rst_hs", vga_hs, 1);
            chk("rst_vs", vga_vs, 1);
            chk("rst_blank_n", blank_n, 0);
            chk("rst_vga_clk", vga_clk, 0);
            chk("rst_frame_start", frame_start, 0);
            chk("rst_frame_count", frame_count, 0);
        end else begin
            k = n / CD;
            h = k % HT;
            v = (k / HT) % VT;
            a = (h < HA) && (v < VA);
            chk("x_pixel", x_pixel, a ? h : 0);
            chk("y_pixel", y_pixel, a ? v : 0);
            chk("vga_clk", vga_clk, (n % CD) >= CD / 2);
            chk("frame_start", frame_start, (n % CD == 0) && (k > 0) && (k % FT == 0));
            chk("frame_count", frame_count, (k / FT) % 65536);
            if (k < PD) begin
                ehs = 1'b1; evs = 1'b1; aj = 1'b0; er = '0; eg = '0; eb = '0;
            end else begin
                j = k - PD;
                hj = j % HT;
                vj = (j / HT) % VT;
                aj = (hj < HA) && (vj < VA);
                ehs = !(hj >= HA + HF && hj < HA + HF + HS);
                evs = !(vj >= VA + VF && vj < VA + VF + VS);
                er = aj ? 8'(hj) ^ kr : 8'd0;
                eg = aj ? 8'(vj) ^ kg : 8'd0;
                eb = aj ? 8'(hj + vj) ^ kb : 8'd0;
            end
            chk("vga_hs", vga_hs, ehs);
            chk("vga_vs", vga_vs, evs);
            chk("blank_n", blank_n, aj);
            chk("vga_r", vga_r, er);
            chk("vga_g", vga_g, eg);
            chk("vga_b", vga_b, eb);
        end
        chk("sync_n", sync_n, 0);
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check_all();
            if (frame_start === 1'b1) begin
                pulses++;
                if (last_pulse >= 0)
                    chk("frame_spacing", n - last_pulse, FT * CD);
                last_pulse = n;
            end
        end
    endtask

    task automatic new_keys();
        kr = 8'($urandom);
        kg = 8'($urandom);
        kb = 8'($urandom);
    endtask

    initial begin
        new_keys();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk) check_all();
        rst_n = 1'b1;
        in_reset = 1'b0;
        n = 0;
        run(3 * FT * CD + $urandom_range(1, 3 * CD));
        chk("three_pulses", pulses, 3);
        chk("three_frames", frame_count, 3);
        run($urandom_range(FT * CD / 4, FT * CD / 2));
        @(posedge clk);
        #2 rst_n = 1'b0;
        in_reset = 1'b1;
        #1 check_all();
        new_keys();
        repeat (2) @(negedge clk) check_all();
        rst_n = 1'b1;
        in_reset = 1'b0;
        n = 0;
        pulses = 0;
        last_pulse = -1;
        run(FT * CD + 10);
        chk("pulse_after_reset", pulses, 1);
        chk("count_after_reset", frame_count, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
